// File: rtl/pcm_sample_pump.sv
// PCM sample pump: paces FIFO reads at the audio rate, applies volume/fade gain, and drives the DAC.
// Optional `PCM_PUMP_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module pcm_sample_pump #(
  parameter int TICK_DIV  = 2000,
  parameter int FADE_STEP = 8
) (
  input  logic        clk96m,
  input  logic        rst,
  input  logic        play,
  input  logic [7:0]  volume,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd_en,
  output logic [15:0] pcm,
  output logic        sample_strobe,
  output logic        underrun,
  output logic [1:0]  state
`ifdef PCM_PUMP_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_FADE = 2'b10} state_t;

  logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
  state_t             state_q, state_d;
  logic [7:0]         gain_q, gain_d;
  logic [15:0]        sample_q, sample_d;
  logic [3:1]         vld_pipe_q, vld_pipe_d;
  logic [3:1]         fin_pipe_q, fin_pipe_d;
  logic [2:1]         rd_pipe_q, rd_pipe_d;
  logic               underrun_q, underrun_d;
  logic [15:0]        pcm_q, pcm_d;
  logic               strobe_q, strobe_d;
  logic               tick, launch, fin;
  logic signed [24:0] product;
  logic [15:0]        scaled;

  always_comb begin
    tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    state_d    = state_q;
    gain_d     = gain_q;
    launch     = 1'b0;
    fin        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_PLAY;
          gain_d  = volume;
        end
      end
      S_PLAY: begin
        launch = tick;
        if (!play)     state_d = S_FADE;
        else if (tick) gain_d  = volume;
      end
      S_FADE: begin
        // Re-entering PLAY keeps the faded gain; volume is reloaded on the next tick.
        if (play) begin
          state_d = S_PLAY;
          launch  = tick;
        end else if (tick) begin
          if (gain_q == 8'd0) begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end else begin
            launch = 1'b1;
            gain_d = (gain_q >= 8'(FADE_STEP)) ? gain_q - 8'(FADE_STEP) : 8'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline: [1] pop/underrun, [2] capture, [3] multiply and pcm update.
  // The final fade tick rides the pipeline only to force midscale onto the DAC.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[2:1], launch | fin};
    fin_pipe_d = {fin_pipe_q[2:1], fin};
    rd_pipe_d  = {rd_pipe_q[1], launch & ~fifo_empty};
    underrun_d = launch & fifo_empty;

    sample_d = sample_q;
    if (rd_pipe_q[2]) sample_d = fifo_data;
    if (fin)          sample_d = '0;

    product  = $signed(sample_q) * $signed({1'b0, gain_q});
    scaled   = 16'(product >>> 8);
    strobe_d = vld_pipe_q[3];
    pcm_d    = pcm_q;
    if (vld_pipe_q[3]) pcm_d = fin_pipe_q[3] ? 16'h8000 : scaled ^ 16'h8000;
  end

  always_ff @(posedge clk96m) begin
    if (rst) begin
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      gain_q     <= '0;
      sample_q   <= '0;
      vld_pipe_q <= '0;
      fin_pipe_q <= '0;
      rd_pipe_q  <= '0;
      underrun_q <= 1'b0;
      pcm_q      <= 16'h8000;
      strobe_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      gain_q     <= gain_d;
      sample_q   <= sample_d;
      vld_pipe_q <= vld_pipe_d;
      fin_pipe_q <= fin_pipe_d;
      rd_pipe_q  <= rd_pipe_d;
      underrun_q <= underrun_d;
      pcm_q      <= pcm_d;
      strobe_q   <= strobe_d;
    end
  end

`ifdef PCM_PUMP_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q, und_cnt_d;

  always_comb begin
    und_cnt_d = und_cnt_q;
    if (state_q == S_IDLE && state_d == S_PLAY)    und_cnt_d = '0;
    else if (underrun_q && und_cnt_q != 16'hFFFF) und_cnt_d = und_cnt_q + 16'd1;
  end

  always_ff @(posedge clk96m) begin
    if (rst) und_cnt_q <= '0;
    else     und_cnt_q <= und_cnt_d;
  end

  assign underrun_count = und_cnt_q;
`endif

  assign fifo_rd_en    = rd_pipe_q[1];
  assign underrun      = underrun_q;
  assign pcm           = pcm_q;
  assign sample_strobe = strobe_q;
  assign state         = state_q;

endmodule
